spi_slave: RTL and testbench

//  SPI responder (target) for the SPI master link; lets the FPGA act as the

---
 rtl/spi_slave.sv | 264 ++++++++++++++++++++++++++
 tb/tb_spi_slave.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI target with oversampled bus inputs, all four SPI modes, MSB/LSB-first,
// a one-word TX holding buffer and an RX holding register with sticky error flags.
`timescale 1ns/1ps
module spi_slave #(
  parameter int WORD_LEN    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                lsbfirst,
  input  logic [WORD_LEN-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [WORD_LEN-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ack,
  output logic                rx_overrun,
  output logic                tx_underrun,
  input  logic                clr_flags,
  output logic                busy,
  input  logic                sck,
  input  logic                mosi,
  input  logic                ss,
  output logic                miso,
  output logic                miso_oe
);

  localparam int CW = (WORD_LEN > 2) ? $clog2(WORD_LEN) : 1;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  function automatic logic first_bit(input logic [WORD_LEN-1:0] w, input logic lsb);
    return lsb ? w[0] : w[WORD_LEN-1];
  endfunction

  function automatic logic [WORD_LEN-1:0] shift_out(input logic [WORD_LEN-1:0] w,
                                                     input logic lsb);
    return lsb ? {1'b1, w[WORD_LEN-1:1]} : {w[WORD_LEN-2:0], 1'b1};
  endfunction

  function automatic logic [WORD_LEN-1:0] shift_in(input logic [WORD_LEN-1:0] w,
                                                    input logic b, input logic lsb);
    return lsb ? {b, w[WORD_LEN-1:1]} : {w[WORD_LEN-2:0], b};
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   armed_q, armed_d;
  logic                   sck_prev_q, sck_prev_d;
  logic [0:0]             state_q, state_d;
  logic [1:0]             mode_lat_q, mode_lat_d;
  logic                   lsb_lat_q, lsb_lat_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   fresh_q, fresh_d;
  logic                   commit_q, commit_d;
  logic                   commit_pop_q, commit_pop_d;
  logic                   rx_done_q, rx_done_d;
  logic                   tx_full_q, tx_full_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [WORD_LEN-1:0]    rx_data_q, rx_data_d;
  logic                   rx_overrun_q, rx_overrun_d;
  logic                   tx_underrun_q, tx_underrun_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic [WORD_LEN-1:0]    sho_q, sho_d;
  logic [WORD_LEN-1:0]    shi_q, shi_d;
  logic [WORD_LEN-1:0]    tx_buf_q, tx_buf_d;

  logic                sck_s, mosi_s, ss_s;
  logic                sck_rise, sck_fall, lead, trail, sample_edge, shift_edge;
  logic [WORD_LEN-1:0] tx_next;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign lead        = mode_lat_q[1] ? sck_fall : sck_rise;
  assign trail       = mode_lat_q[1] ? sck_rise : sck_fall;
  assign sample_edge = mode_lat_q[0] ? trail : lead;
  assign shift_edge  = mode_lat_q[0] ? lead : trail;
  assign tx_next     = tx_full_q ? tx_buf_q : '1;

  always_comb begin
    sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], sck};
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ss_sync_d     = {ss_sync_q[SYNC_STAGES-2:0], ss};
    fill_d        = {fill_q[SYNC_STAGES-2:0], 1'b1};
    // Only a genuinely observed idle ss arms the FSM, so a reset mid-transfer waits for a fresh ss cycle.
    armed_d       = armed_q | (fill_q[SYNC_STAGES-1] & ss_s);
    sck_prev_d    = sck_s;
    state_d       = state_q;
    mode_lat_d    = mode_lat_q;
    lsb_lat_d     = lsb_lat_q;
    cnt_d         = cnt_q;
    fresh_d       = fresh_q;
    commit_d      = commit_q;
    commit_pop_d  = commit_pop_q;
    rx_done_d     = 1'b0;
    tx_full_d     = tx_full_q;
    rx_valid_d    = rx_valid_q;
    rx_data_d     = rx_data_q;
    rx_overrun_d  = rx_overrun_q;
    tx_underrun_d = tx_underrun_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    sho_d         = sho_q;
    shi_d         = shi_q;
    tx_buf_d      = tx_buf_q;

    if (tx_valid && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end
    if (rx_ack) rx_valid_d = 1'b0;
    if (clr_flags) begin
      rx_overrun_d  = 1'b0;
      tx_underrun_d = 1'b0;
    end
    if (rx_done_q) begin
      rx_data_d  = shi_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) rx_overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (armed_q && !ss_s) begin
          state_d    = ST_SHIFT;
          mode_lat_d = mode;
          lsb_lat_d  = lsbfirst;
          cnt_d      = '0;
          commit_d   = 1'b0;
          miso_oe_d  = 1'b1;
          if (tx_full_q) tx_full_d = 1'b0;
          else           tx_underrun_d = 1'b1;
          if (!mode[0]) begin
            miso_d  = first_bit(tx_next, lsbfirst);
            sho_d   = shift_out(tx_next, lsbfirst);
            fresh_d = 1'b0;
          end else begin
            sho_d   = tx_next;
            fresh_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (ss_s) begin
          state_d   = ST_IDLE;
          miso_oe_d = 1'b0;
          miso_d    = 1'b1;
          cnt_d     = '0;
          commit_d  = 1'b0;
          fresh_d   = 1'b0;
        end else begin
          if (sample_edge) begin
            shi_d = shift_in(shi_q, mosi_s, lsb_lat_q);
            if (cnt_q == CW'(WORD_LEN - 1)) begin
              cnt_d     = '0;
              rx_done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
            // CPHA=0 pre-drives the next word's first bit; the buffer is consumed only once the master clocks it.
            if (commit_q) begin
              commit_d = 1'b0;
              if (commit_pop_q) tx_full_d = 1'b0;
              else              tx_underrun_d = 1'b1;
            end
          end
          if (shift_edge) begin
            if (fresh_q) begin
              miso_d  = first_bit(sho_q, lsb_lat_q);
              sho_d   = shift_out(sho_q, lsb_lat_q);
              fresh_d = 1'b0;
            end else if (cnt_q == '0) begin
              miso_d = first_bit(tx_next, lsb_lat_q);
              sho_d  = shift_out(tx_next, lsb_lat_q);
              if (mode_lat_q[0]) begin
                if (tx_full_q) tx_full_d = 1'b0;
                else           tx_underrun_d = 1'b1;
              end else begin
                commit_d     = 1'b1;
                commit_pop_d = tx_full_q;
              end
            end else begin
              miso_d = first_bit(sho_q, lsb_lat_q);
              sho_d  = shift_out(sho_q, lsb_lat_q);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q    <= '0;
      mosi_sync_q   <= '0;
      ss_sync_q     <= '1;
      fill_q        <= '0;
      armed_q       <= 1'b0;
      sck_prev_q    <= 1'b0;
      state_q       <= ST_IDLE;
      mode_lat_q    <= 2'b00;
      lsb_lat_q     <= 1'b0;
      cnt_q         <= '0;
      fresh_q       <= 1'b0;
      commit_q      <= 1'b0;
      commit_pop_q  <= 1'b0;
      rx_done_q     <= 1'b0;
      tx_full_q     <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_q        <= 1'b1;
      miso_oe_q     <= 1'b0;
    end else begin
      sck_sync_q    <= sck_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      ss_sync_q     <= ss_sync_d;
      fill_q        <= fill_d;
      armed_q       <= armed_d;
      sck_prev_q    <= sck_prev_d;
      state_q       <= state_d;
      mode_lat_q    <= mode_lat_d;
      lsb_lat_q     <= lsb_lat_d;
      cnt_q         <= cnt_d;
      fresh_q       <= fresh_d;
      commit_q      <= commit_d;
      commit_pop_q  <= commit_pop_d;
      rx_done_q     <= rx_done_d;
      tx_full_q     <= tx_full_d;
      rx_valid_q    <= rx_valid_d;
      rx_data_q     <= rx_data_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
    end
  end

  // Pure data registers: their contents are only consumed under control of the reset flags above.
  always_ff @(posedge clk) begin
    sho_q    <= sho_d;
    shi_q    <= shi_d;
    tx_buf_q <= tx_buf_d;
  end

  assign tx_ready    = ~tx_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = ~ss_s;
  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master drives words in each
// mode and the received/returned data and status flags are compared with hand values.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       lsbfirst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       rx_overrun;
  logic       tx_underrun;
  logic       clr_flags = 1'b0;
  logic       busy;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       ss = 1'b1;
  logic       miso;
  logic       miso_oe;

  int n_checks = 0;
  int n_fail   = 0;

  spi_slave #(.WORD_LEN(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .lsbfirst(lsbfirst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .clr_flags(clr_flags),
    .busy(busy), .sck(sck), .mosi(mosi), .ss(ss), .miso(miso), .miso_oe(miso_oe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic half_bit();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic select(input logic [1:0] md, input logic lsb);
    mode     = md;
    lsbfirst = lsb;
    sck      = md[1];
    half_bit();
    half_bit();
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("push_ready", {15'd0, tx_ready}, 16'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    int b;
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      b = lsbfirst ? i : 7 - i;
      if (!mode[0]) begin
        mosi = mo[b];
        half_bit();
        mi[b] = miso;
        sck = ~mode[1];
        half_bit();
        sck = mode[1];
      end else begin
        half_bit();
        sck  = ~mode[1];
        mosi = mo[b];
        half_bit();
        mi[b] = miso;
        sck = mode[1];
      end
    end
    half_bit();
  endtask

  task automatic ss_release();
    ss = 1'b1;
    half_bit();
    half_bit();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] mi, mi2;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_ready", {15'd0, tx_ready}, 16'd1);
    check_eq("rst_rx_valid", {15'd0, rx_valid}, 16'd0);
    check_eq("rst_rx_data", {8'd0, rx_data}, 16'h00);
    check_eq("rst_miso", {15'd0, miso}, 16'd1);
    check_eq("rst_miso_oe", {15'd0, miso_oe}, 16'd0);
    check_eq("rst_busy", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Mode 0, MSB first
    select(2'b00, 1'b0);
    push(8'hA5);
    check_eq("m0_tx_ready_low", {15'd0, tx_ready}, 16'd0);
    ss = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("m0_busy", {15'd0, busy}, 16'd1);
    check_eq("m0_oe", {15'd0, miso_oe}, 16'd1);
    check_eq("m0_tx_ready_pop", {15'd0, tx_ready}, 16'd1);
    spi_bits(8'h3C, 8, mi);
    ss_release();
    check_eq("m0_master_rx", {8'd0, mi}, 16'hA5);
    check_eq("m0_rx_data", {8'd0, rx_data}, 16'h3C);
    check_eq("m0_rx_valid", {15'd0, rx_valid}, 16'd1);
    check_eq("m0_flags", {14'd0, rx_overrun, tx_underrun}, 16'd0);
    check_eq("m0_oe_off", {15'd0, miso_oe}, 16'd0);
    check_eq("m0_busy_off", {15'd0, busy}, 16'd0);
    pulse_ack();
    check_eq("m0_ack", {15'd0, rx_valid}, 16'd0);
    pulse_ack();
    check_eq("ack_noop", {15'd0, rx_valid}, 16'd0);

    // Mode 3, LSB first
    select(2'b11, 1'b1);
    push(8'h81);
    ss = 1'b0;
    spi_bits(8'h0F, 8, mi);
    ss_release();
    check_eq("m3_master_rx", {8'd0, mi}, 16'h81);
    check_eq("m3_rx_data", {8'd0, rx_data}, 16'h0F);
    check_eq("m3_flags", {14'd0, rx_overrun, tx_underrun}, 16'd0);
    pulse_ack();

    // Back-to-back words with ss held low
    select(2'b00, 1'b0);
    push(8'h11);
    ss = 1'b0;
    repeat (6) @(negedge clk);
    push(8'h22);
    spi_bits(8'hAA, 8, mi);
    check_eq("b2b_rx1", {8'd0, rx_data}, 16'hAA);
    pulse_ack();
    spi_bits(8'h55, 8, mi2);
    ss_release();
    check_eq("b2b_master1", {8'd0, mi}, 16'h11);
    check_eq("b2b_master2", {8'd0, mi2}, 16'h22);
    check_eq("b2b_rx2", {8'd0, rx_data}, 16'h55);
    check_eq("b2b_flags", {14'd0, rx_overrun, tx_underrun}, 16'd0);
    pulse_ack();

    // Empty TX and no ack over two words
    spi_bits(8'h00, 0, mi);
    ss = 1'b0;
    spi_bits(8'hC3, 8, mi);
    spi_bits(8'h5A, 8, mi2);
    ss_release();
    check_eq("emp_master1", {8'd0, mi}, 16'hFF);
    check_eq("emp_master2", {8'd0, mi2}, 16'hFF);
    check_eq("emp_underrun", {15'd0, tx_underrun}, 16'd1);
    check_eq("emp_overrun", {15'd0, rx_overrun}, 16'd1);
    check_eq("emp_rx_data", {8'd0, rx_data}, 16'h5A);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    @(negedge clk);
    check_eq("clr_flags", {14'd0, rx_overrun, tx_underrun}, 16'd0);
    check_eq("clr_keeps_valid", {15'd0, rx_valid}, 16'd1);
    pulse_ack();

    // Abort after 5 bits in mode 1, then a full word
    select(2'b01, 1'b0);
    push(8'h3A);
    ss = 1'b0;
    spi_bits(8'hF0, 5, mi);
    ss_release();
    check_eq("abort_rx_valid", {15'd0, rx_valid}, 16'd0);
    check_eq("abort_oe", {15'd0, miso_oe}, 16'd0);
    check_eq("abort_miso", {15'd0, miso}, 16'd1);
    push(8'h4B);
    ss = 1'b0;
    spi_bits(8'h96, 8, mi);
    ss_release();
    check_eq("m1_master_rx", {8'd0, mi}, 16'h4B);
    check_eq("m1_rx_data", {8'd0, rx_data}, 16'h96);
    check_eq("m1_rx_valid", {15'd0, rx_valid}, 16'd1);
    pulse_ack();

    // Reset at bit 3
    select(2'b00, 1'b0);
    push(8'h77);
    ss = 1'b0;
    spi_bits(8'h00, 3, mi);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("mid_rst_tx_ready", {15'd0, tx_ready}, 16'd1);
    check_eq("mid_rst_oe", {15'd0, miso_oe}, 16'd0);
    check_eq("mid_rst_miso", {15'd0, miso}, 16'd1);
    check_eq("mid_rst_busy", {15'd0, busy}, 16'd0);
    check_eq("mid_rst_rx_data", {8'd0, rx_data}, 16'h00);
    rst = 1'b0;
    spi_bits(8'hFF, 5, mi);
    check_eq("post_rst_idle_valid", {15'd0, rx_valid}, 16'd0);
    check_eq("post_rst_idle_oe", {15'd0, miso_oe}, 16'd0);
    ss_release();
    push(8'hE7);
    ss = 1'b0;
    spi_bits(8'h18, 8, mi);
    ss_release();
    check_eq("post_rst_master", {8'd0, mi}, 16'hE7);
    check_eq("post_rst_rx_data", {8'd0, rx_data}, 16'h18);
    check_eq("post_rst_flags", {14'd0, rx_overrun, tx_underrun}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
